ram_access_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 8051 internal data RAM (lower RAM, SFR and indirect upper RAM; 8-bit address, 8-bit data).
- Shares the single RAM port between two requesters: port A (core execute unit) and port B (interrupt/stack unit).
- Performs byte read, byte write, bit read and bit write.
- Bit operations run as a read-modify-write over byte accesses, so the RAM bit path is never used.

---
 rtl/ram_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//
// Sequencer and arbiter in front of the 8051 internal data RAM (lower RAM,
// SFR space and indirect upper RAM). Two requesters share one byte-wide RAM
// port:
//   port A - core execute unit
//   port B - interrupt / stack unit
// Supported operations: byte read, byte write, bit read, bit write. Bit
// operations are carried out as read-modify-write over byte accesses, so the
// RAM's own bit path is never used (ram_is_bit / ram_in_bit are tied low).
//
// Ports
//   clock, reset           system clock, synchronous active-high reset
//   {a,b}_req              request, held by the requester until {a,b}_ack
//   {a,b}_op               00 byte rd, 01 byte wr, 10 bit rd, 11 bit wr
//   {a,b}_addr             byte address (byte ops) or bit address (bit ops)
//   {a,b}_wdata/_wbit      byte / bit write value
//   {a,b}_ind              indirect flag, byte ops only
//   {a,b}_ack              one-cycle pulse, request accepted
//   {a,b}_done             one-cycle pulse, operation complete
//   rdata, rbit            read byte / bit, valid while a done pulse is high
//   busy                   high whenever the sequencer is not idle
//   ram_*                  RAM port; ram_rdata is valid in the ram_rd cycle
//
// Every output except the two tied-low bit-path signals comes straight from a
// flop. The next-state logic therefore computes each output from the state
// being entered, so an output is high in exactly the cycle its state lasts.

module ram_access_ctrl #(
  parameter logic [7:0] LRAM_BIT_BASE = 8'h20,
  parameter bit         RESET_LAST_B  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,

  input  logic       a_req,
  input  logic [1:0] a_op,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_wbit,
  input  logic       a_ind,
  output logic       a_ack,
  output logic       a_done,

  input  logic       b_req,
  input  logic [1:0] b_op,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  input  logic       b_wbit,
  input  logic       b_ind,
  output logic       b_ack,
  output logic       b_done,

  output logic [7:0] rdata,
  output logic       rbit,
  output logic       busy,

  output logic [7:0] ram_addr,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic [7:0] ram_wdata,
  output logic       ram_ind,
  output logic       ram_is_bit,
  output logic       ram_in_bit,
  input  logic [7:0] ram_rdata
);

  localparam logic [1:0] OpByteRd = 2'b00;
  localparam logic [1:0] OpByteWr = 2'b01;
  localparam logic [1:0] OpBitRd  = 2'b10;
  localparam logic [1:0] OpBitWr  = 2'b11;

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e     state_q, state_d;
  logic       last_b_q, last_b_d;   // 1: port B was granted most recently
  logic       gnt_b_q, gnt_b_d;     // port owning the current operation
  logic [1:0] op_q, op_d;
  logic [2:0] bit_sel_q, bit_sel_d;
  logic       wbit_q, wbit_d;
  logic [7:0] hold_q, hold_d;       // byte captured in the RD cycle

  logic       a_ack_q, a_ack_d;
  logic       b_ack_q, b_ack_d;
  logic       a_done_q, a_done_d;
  logic       b_done_q, b_done_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rbit_q, rbit_d;
  logic       busy_q, busy_d;
  logic [7:0] ram_addr_q, ram_addr_d;
  logic       ram_rd_q, ram_rd_d;
  logic       ram_wr_q, ram_wr_d;
  logic [7:0] ram_wdata_q, ram_wdata_d;
  logic       ram_ind_q, ram_ind_d;

  // Winner of the current arbitration round and its request fields.
  logic       win_b;
  logic [1:0] win_op;
  logic [7:0] win_addr;
  logic [7:0] win_wdata;
  logic       win_wbit;
  logic       win_ind;
  logic [7:0] win_byte_addr;

  // Byte read in the RD cycle with the selected bit replaced (bit write).
  logic [7:0] merged_byte;

  // Bit address to byte address. Lower-RAM bits 00..7F live in 16 bytes
  // starting at LRAM_BIT_BASE; bits 80..FF address SFRs whose byte address
  // is the bit address with the low three bits cleared.
  function automatic logic [7:0] map_bit_addr(input logic [7:0] bit_addr);
    if (bit_addr[7]) begin
      return {bit_addr[7:3], 3'b000};
    end
    return LRAM_BIT_BASE + {4'h0, bit_addr[6:3]};
  endfunction

  // On a tie the port not granted last time wins.
  always_comb begin
    win_b     = b_req & (~a_req | ~last_b_q);
    win_op    = win_b ? b_op    : a_op;
    win_addr  = win_b ? b_addr  : a_addr;
    win_wdata = win_b ? b_wdata : a_wdata;
    win_wbit  = win_b ? b_wbit  : a_wbit;
    win_ind   = win_b ? b_ind   : a_ind;
    if (win_op[1]) begin
      win_byte_addr = map_bit_addr(win_addr);
    end else begin
      win_byte_addr = win_addr;
    end
  end

  always_comb begin
    merged_byte            = ram_rdata;
    merged_byte[bit_sel_q] = wbit_q;
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    gnt_b_d     = gnt_b_q;
    op_d        = op_q;
    bit_sel_d   = bit_sel_q;
    wbit_d      = wbit_q;
    hold_d      = hold_q;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    a_done_d    = 1'b0;
    b_done_d    = 1'b0;
    rdata_d     = rdata_q;
    rbit_d      = rbit_q;
    ram_addr_d  = ram_addr_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    ram_ind_d   = ram_ind_q;

    unique case (state_q)
      StIdle: begin
        if (a_req || b_req) begin
          gnt_b_d    = win_b;
          last_b_d   = win_b;
          op_d       = win_op;
          bit_sel_d  = win_addr[2:0];
          wbit_d     = win_wbit;
          ram_addr_d = win_byte_addr;
          // Bit accesses always hit the direct space.
          ram_ind_d  = win_op[1] ? 1'b0 : win_ind;
          a_ack_d    = ~win_b;
          b_ack_d    = win_b;
          if (win_op == OpByteWr) begin
            state_d     = StWr;
            ram_wr_d    = 1'b1;
            ram_wdata_d = win_wdata;
          end else begin
            state_d  = StRd;
            ram_rd_d = 1'b1;
          end
        end
      end

      StRd: begin
        hold_d = ram_rdata;
        if (op_q == OpBitWr) begin
          state_d     = StWr;
          ram_wr_d    = 1'b1;
          ram_wdata_d = merged_byte;
        end else begin
          state_d  = StDone;
          a_done_d = ~gnt_b_q;
          b_done_d = gnt_b_q;
          rdata_d  = ram_rdata;
          rbit_d   = ram_rdata[bit_sel_q];
        end
      end

      StWr: begin
        state_d  = StDone;
        a_done_d = ~gnt_b_q;
        b_done_d = gnt_b_q;
        rdata_d  = hold_q;
        rbit_d   = hold_q[bit_sel_q];
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      last_b_q    <= RESET_LAST_B;
      gnt_b_q     <= 1'b0;
      op_q        <= OpByteRd;
      bit_sel_q   <= 3'd0;
      wbit_q      <= 1'b0;
      hold_q      <= 8'h00;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_done_q    <= 1'b0;
      b_done_q    <= 1'b0;
      rdata_q     <= 8'h00;
      rbit_q      <= 1'b0;
      busy_q      <= 1'b0;
      ram_addr_q  <= 8'h00;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
      ram_ind_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      gnt_b_q     <= gnt_b_d;
      op_q        <= op_d;
      bit_sel_q   <= bit_sel_d;
      wbit_q      <= wbit_d;
      hold_q      <= hold_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_done_q    <= a_done_d;
      b_done_q    <= b_done_d;
      rdata_q     <= rdata_d;
      rbit_q      <= rbit_d;
      busy_q      <= busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_ind_q   <= ram_ind_d;
    end
  end

  assign a_ack      = a_ack_q;
  assign b_ack      = b_ack_q;
  assign a_done     = a_done_q;
  assign b_done     = b_done_q;
  assign rdata      = rdata_q;
  assign rbit       = rbit_q;
  assign busy       = busy_q;
  assign ram_addr   = ram_addr_q;
  assign ram_rd     = ram_rd_q;
  assign ram_wr     = ram_wr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_ind    = ram_ind_q;
  assign ram_is_bit = 1'b0;
  assign ram_in_bit = 1'b0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: a byte-array RAM behind the DUT, a
// transaction-level model that predicts per-cycle outputs from the latency
// and arbitration rules, a per-cycle compare process, and directed tests with
// literal expectations.

module tb_ram_access_ctrl;

  localparam int NE = 4096;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       a_req = 1'b0, b_req = 1'b0;
  logic [1:0] a_op = 2'b00, b_op = 2'b00;
  logic [7:0] a_addr = 8'h00, b_addr = 8'h00;
  logic [7:0] a_wdata = 8'h00, b_wdata = 8'h00;
  logic       a_wbit = 1'b0, b_wbit = 1'b0;
  logic       a_ind = 1'b0, b_ind = 1'b0;
  logic       a_ack, b_ack, a_done, b_done;
  logic [7:0] rdata;
  logic       rbit, busy;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_rd, ram_wr, ram_ind, ram_is_bit, ram_in_bit;

  ram_access_ctrl #(
    .LRAM_BIT_BASE (8'h20),
    .RESET_LAST_B  (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .a_req      (a_req),
    .a_op       (a_op),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_wbit     (a_wbit),
    .a_ind      (a_ind),
    .a_ack      (a_ack),
    .a_done     (a_done),
    .b_req      (b_req),
    .b_op       (b_op),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_wbit     (b_wbit),
    .b_ind      (b_ind),
    .b_ack      (b_ack),
    .b_done     (b_done),
    .rdata      (rdata),
    .rbit       (rbit),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .ram_wdata  (ram_wdata),
    .ram_ind    (ram_ind),
    .ram_is_bit (ram_is_bit),
    .ram_in_bit (ram_in_bit),
    .ram_rdata  (ram_rdata)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // RAM seen by the DUT.
  logic [7:0] ram_mem [256];
  assign ram_rdata = ram_mem[ram_addr];
  always @(posedge clock) if (ram_wr) ram_mem[ram_addr] <= ram_wdata;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (edge %0d): got %0h, required %0h", nm, edge_n, act, exp);
    end
  endtask

  // Expected outputs after each edge.
  bit       e_a_ack [NE], e_b_ack [NE], e_a_done [NE], e_b_done [NE], e_busy [NE];
  bit       e_rd [NE], e_wr [NE], e_ind [NE], e_crd [NE], e_crb [NE], e_rbit [NE];
  bit [7:0] e_addr [NE], e_wdata [NE], e_rdata [NE];

  // Model state.
  logic [7:0] model_mem [256];
  int         free_at = 0;
  bit         m_last_b = 1'b1;
  bit         pend_v = 1'b0;
  int         pend_edge = 0;
  logic [7:0] pend_addr, pend_old;

  task automatic clr_slot(input int i);
    e_a_ack[i] = 0; e_b_ack[i] = 0; e_a_done[i] = 0; e_b_done[i] = 0; e_busy[i] = 0;
    e_rd[i] = 0; e_wr[i] = 0; e_ind[i] = 0; e_crd[i] = 0; e_crb[i] = 0; e_rbit[i] = 0;
    e_addr[i] = 0; e_wdata[i] = 0; e_rdata[i] = 0;
  endtask

  always @(posedge clock) begin
    bit         gb;
    logic [1:0] op;
    logic [7:0] ad, wd, byte_a, old, nv;
    logic       wb, ind;
    logic [2:0] sel;
    int         n, len;
    edge_n = edge_n + 1;
    if (reset) begin
      for (int i = edge_n; i < NE; i++) clr_slot(i);
      if (pend_v && pend_edge > edge_n) model_mem[pend_addr] = pend_old;
      pend_v   = 1'b0;
      free_at  = edge_n + 1;
      m_last_b = 1'b1;
    end else if (edge_n >= free_at && (a_req || b_req) && edge_n + 4 < NE) begin
      gb       = b_req && (!a_req || !m_last_b);
      m_last_b = gb;
      op  = gb ? b_op : a_op;
      ad  = gb ? b_addr : a_addr;
      wd  = gb ? b_wdata : a_wdata;
      wb  = gb ? b_wbit : a_wbit;
      ind = gb ? b_ind : a_ind;
      n   = edge_n;
      sel = ad[2:0];
      if (op[1]) byte_a = ad[7] ? {ad[7:3], 3'b000} : 8'h20 + {4'h0, ad[6:3]};
      else byte_a = ad;
      if (op[1]) ind = 1'b0;
      len = (op == 2'b11) ? 3 : 2;
      if (gb) e_b_ack[n] = 1; else e_a_ack[n] = 1;
      for (int k = 0; k < len; k++) e_busy[n + k] = 1;
      if (gb) e_b_done[n + len - 1] = 1; else e_a_done[n + len - 1] = 1;
      free_at = n + len + 1;
      for (int k = 0; k < 2; k++) begin
        e_addr[n + k] = byte_a;
        e_ind[n + k]  = ind;
      end
      old = model_mem[byte_a];
      case (op)
        2'b00: begin
          e_rd[n] = 1; e_crd[n + 1] = 1; e_rdata[n + 1] = old;
        end
        2'b01: begin
          e_wr[n] = 1; e_wdata[n] = wd;
          pend_v = 1; pend_edge = n + 1; pend_addr = byte_a; pend_old = old;
          model_mem[byte_a] = wd;
        end
        2'b10: begin
          e_rd[n] = 1; e_crd[n + 1] = 1; e_rdata[n + 1] = old;
          e_crb[n + 1] = 1; e_rbit[n + 1] = old[sel];
        end
        default: begin
          nv = old; nv[sel] = wb;
          e_rd[n] = 1; e_wr[n + 1] = 1; e_wdata[n + 1] = nv;
          pend_v = 1; pend_edge = n + 2; pend_addr = byte_a; pend_old = old;
          model_mem[byte_a] = nv;
        end
      endcase
    end
  end

  // Per-cycle compare against the model, plus a few observation monitors.
  int         wr_cnt = 0;
  logic [7:0] last_wr_addr, last_wdata;
  logic       last_wr_ind, last_rd_ind;

  always @(negedge clock) begin
    if (ram_wr) begin
      wr_cnt++; last_wr_addr = ram_addr; last_wdata = ram_wdata; last_wr_ind = ram_ind;
    end
    if (ram_rd) last_rd_ind = ram_ind;
    if (chk_en && edge_n < NE) begin
      cmp("a_ack", a_ack, e_a_ack[edge_n]);
      cmp("b_ack", b_ack, e_b_ack[edge_n]);
      cmp("a_done", a_done, e_a_done[edge_n]);
      cmp("b_done", b_done, e_b_done[edge_n]);
      cmp("busy", busy, e_busy[edge_n]);
      cmp("ram_rd", ram_rd, e_rd[edge_n]);
      cmp("ram_wr", ram_wr, e_wr[edge_n]);
      cmp("ram_is_bit", ram_is_bit, 0);
      cmp("ram_in_bit", ram_in_bit, 0);
      if (e_rd[edge_n] || e_wr[edge_n]) begin
        cmp("ram_addr", ram_addr, e_addr[edge_n]);
        cmp("ram_ind", ram_ind, e_ind[edge_n]);
      end
      if (e_wr[edge_n]) cmp("ram_wdata", ram_wdata, e_wdata[edge_n]);
      if (e_crd[edge_n]) cmp("rdata", rdata, e_rdata[edge_n]);
      if (e_crb[edge_n]) cmp("rbit", rbit, e_rbit[edge_n]);
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Issue one request and wait for ack and done (bounded).
  task automatic do_op(input bit pb, input logic [1:0] op, input logic [7:0] ad,
                       input logic [7:0] wd, input logic wb, input logic ind,
                       output int lat_ack, output int lat_done,
                       output logic [7:0] rd_o, output logic rb_o);
    int raise_e, ack_e, done_e;
    @(negedge clock);
    if (pb) begin
      b_op = op; b_addr = ad; b_wdata = wd; b_wbit = wb; b_ind = ind; b_req = 1'b1;
    end else begin
      a_op = op; a_addr = ad; a_wdata = wd; a_wbit = wb; a_ind = ind; a_req = 1'b1;
    end
    raise_e = edge_n;
    ack_e = -1; done_e = -1; rd_o = 8'hxx; rb_o = 1'bx;
    for (int k = 0; k < 20 && ack_e < 0; k++) begin
      @(negedge clock);
      if (pb ? b_ack : a_ack) ack_e = edge_n;
    end
    a_req = 1'b0; b_req = 1'b0;
    if (ack_e < 0) cmp("ack_timeout", 0, 1);
    for (int k = 0; k < 20 && ack_e >= 0 && done_e < 0; k++) begin
      @(negedge clock);
      if (pb ? b_done : a_done) begin
        done_e = edge_n; rd_o = rdata; rb_o = rbit;
      end
    end
    if (ack_e >= 0 && done_e < 0) cmp("done_timeout", 0, 1);
    lat_ack  = ack_e - raise_e;
    lat_done = done_e - ack_e;
  endtask

  initial begin
    int         la, ld, w0;
    logic [7:0] rd_v, saved;
    logic       rb_v;
    bit         seq [3];
    bit         got;

    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 8'(i * 7 + 3);
      model_mem[i] = 8'(i * 7 + 3);
    end
    ram_mem[8'h2F] = 8'h00; model_mem[8'h2F] = 8'h00;
    ram_mem[8'hD0] = 8'h00; model_mem[8'hD0] = 8'h00;
    ram_mem[8'hF8] = 8'h00; model_mem[8'hF8] = 8'h00;

    do_reset();
    chk_en = 1'b1;

    // Byte write then read back.
    w0 = wr_cnt;
    do_op(1'b0, 2'b01, 8'h30, 8'h5A, 1'b0, 1'b0, la, ld, rd_v, rb_v);
    cmp("t1_ack_lat", la, 1);
    cmp("t1_wr_done_lat", ld, 1);
    cmp("t1_wr_cycles", wr_cnt - w0, 1);
    do_op(1'b0, 2'b00, 8'h30, 8'h00, 1'b0, 1'b0, la, ld, rd_v, rb_v);
    cmp("t1_rd_done_lat", ld, 1);
    cmp("t1_rdata", rd_v, 8'h5A);

    // Bit write to bit 7F: RMW on byte 2F.
    do_op(1'b0, 2'b11, 8'h7F, 8'h00, 1'b1, 1'b0, la, ld, rd_v, rb_v);
    cmp("t2_done_lat", ld, 2);
    cmp("t2_wr_addr", last_wr_addr, 8'h2F);
    cmp("t2_wdata", last_wdata, 8'h80);
    cmp("t2_mem", ram_mem[8'h2F], 8'h80);

    // Bit read of 7F.
    do_op(1'b0, 2'b10, 8'h7F, 8'h00, 1'b0, 1'b0, la, ld, rd_v, rb_v);
    cmp("t3_rbit", rb_v, 1);

    // Port B SFR bit write D3, with ind requested but ignored for bit ops.
    do_op(1'b1, 2'b11, 8'hD3, 8'h00, 1'b1, 1'b1, la, ld, rd_v, rb_v);
    cmp("t4_mem", ram_mem[8'hD0], 8'h08);
    cmp("t4_ind", last_wr_ind, 0);

    // Top of bit space maps to F8 bit 7.
    do_op(1'b0, 2'b11, 8'hFF, 8'h00, 1'b1, 1'b0, la, ld, rd_v, rb_v);
    cmp("t4b_wr_addr", last_wr_addr, 8'hF8);
    cmp("t4b_mem", ram_mem[8'hF8], 8'h80);

    // Three ties in a row after reset: A, B, A. Loser's request is dropped.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      a_op = 2'b00; a_addr = 8'h40; a_ind = 1'b0; a_req = 1'b1;
      b_op = 2'b00; b_addr = 8'h41; b_ind = 1'b0; b_req = 1'b1;
      got = 1'b0; seq[r] = 1'b0;
      for (int k = 0; k < 10 && !got; k++) begin
        @(negedge clock);
        if (a_ack || b_ack) begin got = 1'b1; seq[r] = b_ack; end
      end
      a_req = 1'b0; b_req = 1'b0;
      if (!got) cmp("tie_timeout", 0, 1);
      for (int k = 0; k < 10 && busy; k++) @(negedge clock);
    end
    cmp("tie_0_is_a", seq[0], 0);
    cmp("tie_1_is_b", seq[1], 1);
    cmp("tie_2_is_a", seq[2], 0);

    // Reset during the RD cycle of a bit write on bit 05 (byte 20).
    saved = ram_mem[8'h20];
    @(negedge clock);
    a_op = 2'b11; a_addr = 8'h05; a_wbit = ~saved[5]; a_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clock);
      if (a_ack) got = 1'b1;
    end
    if (!got) cmp("abort_ack_timeout", 0, 1);
    cmp("abort_in_rd", ram_rd, 1);
    reset = 1'b1; a_req = 1'b0;
    @(negedge clock);
    cmp("abort_busy", busy, 0);
    cmp("abort_wr", ram_wr, 0);
    cmp("abort_done", a_done, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    cmp("abort_mem", ram_mem[8'h20], saved);

    // Port B indirect byte accesses.
    do_op(1'b1, 2'b01, 8'h90, 8'h11, 1'b0, 1'b1, la, ld, rd_v, rb_v);
    cmp("t7_wr_ind", last_wr_ind, 1);
    do_op(1'b1, 2'b00, 8'h90, 8'h00, 1'b0, 1'b1, la, ld, rd_v, rb_v);
    cmp("t7_rd_ind1", last_rd_ind, 1);
    cmp("t7_rdata", rd_v, 8'h11);
    do_op(1'b1, 2'b00, 8'h90, 8'h00, 1'b0, 1'b0, la, ld, rd_v, rb_v);
    cmp("t7_rd_ind0", last_rd_ind, 0);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
